// File: rtl/audio_dsm_pkg.sv
// Shared constants and types for the stereo ramped delta-sigma audio DAC.
// Pure declarations; no logic.
// Provides default widths, midscale value and the per-channel state enum.
package audio_dsm_pkg;

    localparam int IW_DEF      = 10;
    localparam int RAMP_SH_DEF = 4;
    localparam int MIDSCALE    = 1 << (IW_DEF - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } chan_state_e;

    // Midscale for an arbitrary sample width, so non-default IW still parks at centre.
    function automatic int midscale_of(input int iw);
        return 1 << (iw - 1);
    endfunction

endpackage

// File: rtl/audio_dsm_chan.sv
// One audio channel: linear ramp from cur to a new target, then first-order delta-sigma.
// Latency: dac reflects cur one clock later; a ramp lasts exactly 2^RAMP_SH clocks.
// No backpressure: a strobe always wins and restarts the ramp from the present cur.
module audio_dsm_chan
    import audio_dsm_pkg::*;
#(
    parameter int IW      = IW_DEF,
    parameter int RAMP_SH = RAMP_SH_DEF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_smp,
    input  logic [IW-1:0] din,
    output logic          dac,
    output logic          ramp_nxt
);

    localparam logic [IW-1:0]      MID      = IW'(midscale_of(IW));
    localparam logic [RAMP_SH-1:0] CNT_LAST = '1;

    chan_state_e             state_q, state_d;
    logic [IW-1:0]           cur_q, cur_d;
    logic [IW-1:0]           tgt_q, tgt_d;
    logic signed [IW:0]      step_q, step_d;
    logic [RAMP_SH-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]           acc_q, acc_d;
    logic                    dac_q, dac_d;

    logic [IW:0]             sum;
    logic signed [IW:0]      diff;
    logic signed [IW:0]      cur_step;

    // Next-state: modulator runs on the pre-update cur; strobe overrides any ramp step or final load.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        tgt_d    = tgt_q;
        step_d   = step_q;
        cnt_d    = cnt_q;

        sum      = {1'b0, acc_q} + {1'b0, cur_q};
        acc_d    = sum[IW-1:0];
        dac_d    = sum[IW];

        diff     = $signed({1'b0, din}) - $signed({1'b0, cur_q});
        cur_step = $signed({1'b0, cur_q}) + step_q;

        if (ce_smp) begin
            tgt_d   = din;
            step_d  = diff >>> RAMP_SH;
            cnt_d   = '0;
            state_d = RAMP;
        end else if (state_q == RAMP) begin
            if (cnt_q == CNT_LAST) begin
                // Land exactly on target so truncated steps never leave a residual error.
                cur_d   = tgt_q;
                state_d = IDLE;
            end else begin
                cur_d = cur_step[IW-1:0];
                cnt_d = cnt_q + RAMP_SH'(1);
            end
        end
    end

    // Channel state registers with synchronous reset to a parked midscale output.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= MID;
            tgt_q   <= MID;
            step_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            dac_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dac_q   <= dac_d;
        end
    end

    assign dac      = dac_q;
    assign ramp_nxt = (state_d == RAMP) && !reset;

endmodule

// File: rtl/audio_dsm.sv
// Stereo ramped delta-sigma DAC: mute muxing in front of two independent channels.
// Latency: one clock from cur to dac_l/dac_r; busy is registered alongside channel state.
// No backpressure: every ce_smp is accepted; mute is sampled only on ce_smp.
module audio_dsm
    import audio_dsm_pkg::*;
#(
    parameter int IW      = IW_DEF,
    parameter int RAMP_SH = RAMP_SH_DEF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_smp,
    input  logic [IW-1:0] laudio,
    input  logic [IW-1:0] raudio,
    input  logic          mute,
    output logic          dac_l,
    output logic          dac_r,
    output logic          busy
);

    localparam logic [IW-1:0] MID = IW'(midscale_of(IW));

    logic [IW-1:0] eff_l, eff_r;
    logic          ramp_l, ramp_r;
    logic          busy_q, busy_d;

    // Muted channels target midscale, which is the silent level for unsigned audio.
    always_comb begin
        eff_l  = mute ? MID : laudio;
        eff_r  = mute ? MID : raudio;
        busy_d = ramp_l | ramp_r;
    end

    audio_dsm_chan #(.IW(IW), .RAMP_SH(RAMP_SH)) u_chan_l (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce_smp   (ce_smp),
        .din      (eff_l),
        .dac      (dac_l),
        .ramp_nxt (ramp_l)
    );

    audio_dsm_chan #(.IW(IW), .RAMP_SH(RAMP_SH)) u_chan_r (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce_smp   (ce_smp),
        .din      (eff_r),
        .dac      (dac_r),
        .ramp_nxt (ramp_r)
    );

    // Busy flop tracks the OR of both channels' ramp state in the same cycle it takes effect.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_audio_dsm.sv
// Self-checking bench for audio_dsm with an arithmetic reference model.
// Model advances once per clock using the inputs presented at that edge.
// Outputs and internal cur/target are sampled 1 time unit after each rising edge.
module tb_audio_dsm;
    import audio_dsm_pkg::*;

    localparam int IW   = IW_DEF;
    localparam int RSH  = RAMP_SH_DEF;
    localparam int FS   = 1 << IW;
    localparam int RLEN = 1 << RSH;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic          ce_smp  = 1'b0;
    logic          mute    = 1'b0;
    logic [IW-1:0] laudio  = '0;
    logic [IW-1:0] raudio  = '0;
    logic          dac_l, dac_r, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: values as plain integers, ramp as "cycles remaining".
    int m_cur[2], m_tgt[2], m_step[2], m_left[2], m_acc[2];
    bit m_dac[2];
    bit m_busy;

    audio_dsm #(.IW(IW), .RAMP_SH(RSH)) u_dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce_smp  (ce_smp),
        .laudio  (laudio),
        .raudio  (raudio),
        .mute    (mute),
        .dac_l   (dac_l),
        .dac_r   (dac_r),
        .busy    (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        int eff[2];
        int s;
        eff[0] = mute ? MIDSCALE : int'(laudio);
        eff[1] = mute ? MIDSCALE : int'(raudio);
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                m_cur[c]  = MIDSCALE;
                m_tgt[c]  = MIDSCALE;
                m_step[c] = 0;
                m_left[c] = 0;
                m_acc[c]  = 0;
                m_dac[c]  = 1'b0;
            end else begin
                s        = m_acc[c] + m_cur[c];
                m_dac[c] = (s >= FS);
                m_acc[c] = s % FS;
                if (ce_smp) begin
                    m_tgt[c]  = eff[c];
                    m_step[c] = (eff[c] - m_cur[c]) >>> RSH;
                    m_left[c] = RLEN;
                end else if (m_left[c] > 0) begin
                    m_left[c] = m_left[c] - 1;
                    if (m_left[c] == 0) m_cur[c] = m_tgt[c];
                    else m_cur[c] = (((m_cur[c] + m_step[c]) % FS) + FS) % FS;
                end
            end
        end
        m_busy = (m_left[0] > 0) || (m_left[1] > 0);
        @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe_l(input int val);
        laudio = IW'(val);
        ce_smp = 1'b1;
        tick();
        ce_smp = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce_smp = 1'b1;
        laudio = IW'(900);
        repeat (3) tick();
        ce_smp = 1'b0;
        laudio = '0;
        n_tests++;
        if (int'(u_dut.u_chan_l.cur_q) !== MIDSCALE) begin
            n_fail++; $display("FAIL reset_cur_l: got %0d want %0d", u_dut.u_chan_l.cur_q, MIDSCALE);
        end
        n_tests++;
        if (int'(u_dut.u_chan_r.tgt_q) !== MIDSCALE) begin
            n_fail++; $display("FAIL reset_tgt_r: got %0d want %0d", u_dut.u_chan_r.tgt_q, MIDSCALE);
        end
        n_tests++;
        if ({dac_l, dac_r, busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_outputs: got %b%b%b want 000", dac_l, dac_r, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle_midscale();
        int bad = 0, ones = 0;
        for (int i = 0; i < FS; i++) begin
            tick();
            if (dac_l !== bit'(i % 2)) bad++;
            if (dac_l === 1'b1) ones++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL idle_toggle: %0d cycles off the 0,1,0,1 pattern, want 0", bad);
        end
        n_tests++;
        if (ones !== FS / 2) begin
            n_fail++; $display("FAIL idle_density: got %0d ones want %0d", ones, FS / 2);
        end
        n_tests++;
        if (int'(u_dut.u_chan_l.cur_q) !== MIDSCALE) begin
            n_fail++; $display("FAIL idle_cur: got %0d want %0d", u_dut.u_chan_l.cur_q, MIDSCALE);
        end
    endtask

    task automatic test_ramp_up();
        int bad = 0, busy_cnt = 0, ones = 0;
        strobe_l(768);
        if (busy === 1'b1) busy_cnt++;
        for (int k = 1; k <= RLEN; k++) begin
            tick();
            if (int'(u_dut.u_chan_l.cur_q) !== 512 + 16 * k) bad++;
            if (busy === 1'b1) busy_cnt++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL ramp_trajectory: %0d wrong cur samples, want 0", bad);
        end
        n_tests++;
        if (busy_cnt !== RLEN) begin
            n_fail++; $display("FAIL ramp_busy_len: got %0d cycles want %0d", busy_cnt, RLEN);
        end
        tick();
        for (int i = 0; i < FS; i++) begin
            tick();
            if (dac_l === 1'b1) ones++;
        end
        n_tests++;
        if (ones !== 768) begin
            n_fail++; $display("FAIL ramp_density: got %0d ones want 768", ones);
        end
    endtask

    task automatic test_extremes();
        int ones;
        int vals[2] = '{0, FS - 1};
        foreach (vals[j]) begin
            strobe_l(vals[j]);
            repeat (RLEN + 1) tick();
            n_tests++;
            if (int'(u_dut.u_chan_l.cur_q) !== vals[j]) begin
                n_fail++; $display("FAIL extreme_cur_%0d: got %0d want %0d", vals[j], u_dut.u_chan_l.cur_q, vals[j]);
            end
            ones = 0;
            for (int i = 0; i < FS; i++) begin
                tick();
                if (dac_l === 1'b1) ones++;
            end
            n_tests++;
            if (ones !== vals[j]) begin
                n_fail++; $display("FAIL extreme_density_%0d: got %0d ones want %0d", vals[j], ones, vals[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int held;
        strobe_l(1000);
        repeat (6) tick();
        strobe_l(100);
        for (int k = 1; k <= RLEN; k++) begin
            tick();
            if (int'(u_dut.u_chan_l.cur_q) !== m_cur[0]) bad++;
            if (k == RLEN - 1 && int'(u_dut.u_chan_l.cur_q) === 100) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL restart_trajectory: %0d wrong cur samples, want 0", bad);
        end
        n_tests++;
        if (int'(u_dut.u_chan_l.cur_q) !== 100) begin
            n_fail++; $display("FAIL restart_final: got %0d want 100", u_dut.u_chan_l.cur_q);
        end
        // Strobe on the final ramp cycle: the exact load must be dropped.
        strobe_l(600);
        repeat (RLEN - 1) tick();
        held = m_cur[0];
        strobe_l(300);
        n_tests++;
        if (int'(u_dut.u_chan_l.cur_q) !== held || held === 600) begin
            n_fail++; $display("FAIL coincide_cur: got %0d want %0d", u_dut.u_chan_l.cur_q, held);
        end
        repeat (RLEN + 1) tick();
        n_tests++;
        if (int'(u_dut.u_chan_l.cur_q) !== 300) begin
            n_fail++; $display("FAIL coincide_final: got %0d want 300", u_dut.u_chan_l.cur_q);
        end
    endtask

    task automatic test_mute();
        int ones = 0;
        raudio = IW'(FS - 1);
        mute = 1'b1;
        ce_smp = 1'b1;
        tick();
        ce_smp = 1'b0;
        mute = 1'b0;
        n_tests++;
        if (int'(u_dut.u_chan_r.tgt_q) !== MIDSCALE) begin
            n_fail++; $display("FAIL mute_target: got %0d want %0d", u_dut.u_chan_r.tgt_q, MIDSCALE);
        end
        repeat (RLEN + 1) tick();
        n_tests++;
        if (int'(u_dut.u_chan_r.cur_q) !== MIDSCALE) begin
            n_fail++; $display("FAIL mute_cur: got %0d want %0d", u_dut.u_chan_r.cur_q, MIDSCALE);
        end
        for (int i = 0; i < FS; i++) begin
            tick();
            if (dac_r === 1'b1) ones++;
        end
        n_tests++;
        if (ones !== FS / 2) begin
            n_fail++; $display("FAIL mute_density: got %0d ones want %0d", ones, FS / 2);
        end
    endtask

    task automatic test_reset_mid_ramp();
        int bad = 0;
        strobe_l(900);
        repeat (4) tick();
        reset = 1'b1;
        ce_smp = 1'b1;
        tick();
        reset = 1'b0;
        ce_smp = 1'b0;
        n_tests++;
        if (int'(u_dut.u_chan_l.cur_q) !== MIDSCALE || busy !== 1'b0 || dac_l !== 1'b0) begin
            n_fail++; $display("FAIL midramp_reset: cur=%0d busy=%b dac=%b want %0d/0/0",
                               u_dut.u_chan_l.cur_q, busy, dac_l, MIDSCALE);
        end
        for (int i = 0; i < 2 * RLEN; i++) begin
            tick();
            if (int'(u_dut.u_chan_l.cur_q) !== MIDSCALE || busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL midramp_residual: %0d cycles moved after reset, want 0", bad);
        end
    endtask

    task automatic test_random();
        int bad_cur = 0, bad_dac = 0, bad_busy = 0;
        for (int i = 0; i < 3000; i++) begin
            ce_smp = ($urandom_range(5, 0) == 0);
            mute   = ($urandom_range(4, 0) == 0);
            reset  = ($urandom_range(150, 0) == 0);
            laudio = IW'($urandom_range(FS - 1, 0));
            raudio = IW'($urandom_range(FS - 1, 0));
            tick();
            if (int'(u_dut.u_chan_l.cur_q) !== m_cur[0] || int'(u_dut.u_chan_r.cur_q) !== m_cur[1]) bad_cur++;
            if (dac_l !== m_dac[0] || dac_r !== m_dac[1]) bad_dac++;
            if (busy !== m_busy) bad_busy++;
        end
        ce_smp = 1'b0;
        reset  = 1'b0;
        mute   = 1'b0;
        n_tests++;
        if (bad_cur !== 0) begin
            n_fail++; $display("FAIL random_cur: %0d cycles differ from model, want 0", bad_cur);
        end
        n_tests++;
        if (bad_dac !== 0) begin
            n_fail++; $display("FAIL random_dac: %0d cycles differ from model, want 0", bad_dac);
        end
        n_tests++;
        if (bad_busy !== 0) begin
            n_fail++; $display("FAIL random_busy: %0d cycles differ from model, want 0", bad_busy);
        end
    endtask

    initial begin
        foreach (m_cur[c]) begin
            m_cur[c] = 0; m_tgt[c] = 0; m_step[c] = 0; m_left[c] = 0; m_acc[c] = 0; m_dac[c] = 1'b0;
        end
        m_busy = 1'b0;
        test_reset();
        test_idle_midscale();
        test_ramp_up();
        test_extremes();
        test_back_to_back();
        test_mute();
        test_reset_mid_ramp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_dsm.md
AUDIO_DSM -- requirements
Module: audio_dsm

Interface
REQ-001 SHALL have parameter IW, default 10, giving the input sample width in bits (unsigned).
REQ-002 SHALL have parameter RAMP_SH, default 4, giving the interpolation ramp length as 2^RAMP_SH clocks.
REQ-003 SHALL have port clk_sys, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ce_smp, input, 1 bit: new-sample strobe, one clk_sys cycle wide.
REQ-006 SHALL have port laudio, input, IW bits: unsigned left sample.
REQ-007 SHALL have port raudio, input, IW bits: unsigned right sample.
REQ-008 SHALL have port mute, input, 1 bit: level-sensitive mute request.
REQ-009 SHALL have port dac_l, output, 1 bit: left 1-bit delta-sigma stream (drives AUDIO_L).
REQ-010 SHALL have port dac_r, output, 1 bit: right 1-bit delta-sigma stream (drives AUDIO_R).
REQ-011 SHALL have port busy, output, 1 bit: high while either channel is in RAMP.

Function
REQ-012 SHALL contain two identical, independent channels; each has a target register (IW bits), a current value cur (IW bits), a step register (signed, IW+1 bits), a ramp counter (RAMP_SH bits), an accumulator acc (IW bits), and states IDLE and RAMP.
REQ-013 SHALL compute the effective input as midscale 2^(IW-1) when mute=1, and otherwise as laudio or raudio.
REQ-014 SHALL, on any cycle with ce_smp=1 and in either state: latch target to the effective input, set step to (effective input - cur) arithmetically shifted right by RAMP_SH (rounding toward minus infinity), clear the counter, and enter RAMP.
REQ-015 SHALL, in RAMP with ce_smp=0, add step to cur and increment the counter each cycle.
REQ-016 SHALL, on the cycle the counter equals 2^RAMP_SH-1, load cur with target exactly (not cur+step) and return to IDLE, so the ramp lasts exactly 2^RAMP_SH cycles.
REQ-017 SHALL give ce_smp priority when it coincides with the final ramp cycle: the new sample is latched, the ramp restarts from the present cur, and the final load is discarded.
REQ-018 SHALL leave cur unchanged in IDLE.
REQ-019 SHALL compute each cycle {carry, acc_next} = acc + cur as an (IW+1)-bit sum, using the cur value registered before this cycle's update; acc takes the low IW bits and the dac output register takes carry (latency of one clock).
REQ-020 SHALL make the dac output density over any 2^IW consecutive cycles with constant cur equal exactly cur/2^IW; cur=0 SHALL give constant 0.
REQ-021 SHALL sample mute only through ce_smp, so that a mute change takes effect at the next ce_smp and ramps like any other sample.
REQ-022 SHALL drive busy as the OR of the two channels' RAMP states, registered.

Reset
REQ-023 SHALL, while reset=1: set cur and target to 2^(IW-1), acc to 0, step to 0, counter to 0, state to IDLE, dac_l and dac_r to 0, and busy to 0.
REQ-024 SHALL abandon any ramp in progress on reset, with no residual step applied after reset deasserts.
REQ-025 SHALL ignore ce_smp in the same cycle as reset=1.

Structure
REQ-026 SHALL place the IW and RAMP_SH defaults, the MIDSCALE constant, and the channel state enum (IDLE, RAMP) in shared package audio_dsm_pkg.
REQ-027 SHALL implement one channel as sub-module audio_dsm_chan, instantiated twice by audio_dsm, which adds only the mute muxing and the busy OR.

Verification
REQ-028 SHALL check: reset, then no ce_smp -> cur=512 and dac_l toggles 0,1,0,1... with exactly 512 ones in every 1024 cycles.
REQ-029 SHALL check: ce_smp with laudio=768 -> cur goes 528, 544, ... 768, reaching exactly 768 on the 16th cycle after the strobe; busy is high for 16 cycles; afterwards there are exactly 768 ones per 1024 cycles.
REQ-030 SHALL check: laudio=0 then laudio=1023, each settled -> dac_l holds 0 permanently, then gives 1023 ones per 1024 cycles.
REQ-031 SHALL check: ce_smp with laudio=1000 and a second ce_smp (laudio=100) 7 cycles later -> the ramp restarts from the intermediate cur, and cur equals 100 exactly 16 cycles after the second strobe.
REQ-032 SHALL check: mute=1 with a ce_smp while raudio=1023 -> right target becomes 512; at steady state dac_r gives 512 ones per 1024 cycles.
REQ-033 SHALL check: reset asserted in cycle 5 of a ramp -> cur=512, busy=0, dac_l=0 on the next cycle, with no further cur movement.
